// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the convolution output path.
//   out_entry_t        : one finished output word {data, x, y, ch}, sized by
//                        the default data/coordinate widths below.
//   RESULT_PIPE_DEPTH  : depth of the controller's result pipeline; words
//                        already in flight when `ready` drops still arrive.
//   AF_MARGIN_DEF      : default almost_full margin (pipeline depth + 1).
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DATA_WIDTH_DEF    = 32;
    localparam int COORD_WIDTH_DEF   = 32;
    localparam int DEPTH_DEF         = 16;
    localparam int RESULT_PIPE_DEPTH = 5;
    localparam int AF_MARGIN_DEF     = RESULT_PIPE_DEPTH + 1;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0]  data;
        logic [COORD_WIDTH_DEF-1:0] x;
        logic [COORD_WIDTH_DEF-1:0] y;
        logic [COORD_WIDTH_DEF-1:0] ch;
    } out_entry_t;

endpackage

// File: rtl/conv_output_buffer_if.sv
// ---------------------------------------------------------------------------
// conv_output_buffer_if
// Bundles the capture side (from the convolution controller) and the
// valid/ready consumer side of conv_output_buffer.
//   in_valid/in_data/in_x/in_y/in_ch : finished word from the controller
//   out_valid/out_ready              : consumer handshake
//   out_data/out_x/out_y/out_ch      : head entry
//   almost_full, overflow, level     : status back to the controller
// Optional (CONV_OUTPUT_BUFFER_STATS_EN): stall_cycles, words_out, peak_level.
// Modports: master = environment (controller + consumer), slave = buffer.
// ---------------------------------------------------------------------------
interface conv_output_buffer_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF
) ();

    localparam int LW = $clog2(DEPTH) + 1;

    logic                   in_valid;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [COORD_WIDTH-1:0] in_x;
    logic [COORD_WIDTH-1:0] in_y;
    logic [COORD_WIDTH-1:0] in_ch;

    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [COORD_WIDTH-1:0] out_x;
    logic [COORD_WIDTH-1:0] out_y;
    logic [COORD_WIDTH-1:0] out_ch;

    logic                   almost_full;
    logic                   overflow;
    logic [LW-1:0]          level;

`ifdef CONV_OUTPUT_BUFFER_STATS_EN
    logic [31:0]            stall_cycles;
    logic [31:0]            words_out;
    logic [LW-1:0]          peak_level;
`endif

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, out_ready,
        input  out_valid, out_data, out_x, out_y, out_ch,
        input  almost_full, overflow, level
`ifdef CONV_OUTPUT_BUFFER_STATS_EN
        , input stall_cycles, words_out, peak_level
`endif
    );

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
        output out_valid, out_data, out_x, out_y, out_ch,
        output almost_full, overflow, level
`ifdef CONV_OUTPUT_BUFFER_STATS_EN
        , output stall_cycles, words_out, peak_level
`endif
    );

endinterface

// File: rtl/conv_out_fifo_mem.sv
// ---------------------------------------------------------------------------
// conv_out_fifo_mem
// DEPTH x out_entry_t storage for the output buffer.
//   clk        : write clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write slot
//   wr_entry_i : word to store
//   rd_addr_i  : read slot (combinational read)
//   rd_entry_o : contents of rd_addr_i
// ---------------------------------------------------------------------------
module conv_out_fifo_mem
    import conv_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  out_entry_t      wr_entry_i,
    input  logic [AW-1:0]   rd_addr_i,
    output out_entry_t      rd_entry_o
);

    // NOTE: storage has no reset; the pointers define which slots are valid,
    // so clearing the array would only cost flops and reset fan-out.
    out_entry_t mem_q [DEPTH];

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs as they were before the edge.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_entry_i;
        end
    end

    assign rd_entry_o = mem_q[rd_addr_i];

endmodule

// File: rtl/conv_output_buffer.sv
// ---------------------------------------------------------------------------
// conv_output_buffer
// Captures finished convolution output words into a FIFO and presents them
// to a consumer through a registered show-ahead valid/ready port.
//   clk        : clock
//   arst_n_in  : asynchronous reset, active low; discards all contents
//   bus        : conv_output_buffer_if.slave (capture input, consumer output,
//                almost_full / overflow / level status)
// Optional statistics counters are built when CONV_OUTPUT_BUFFER_STATS_EN is
// defined (stall_cycles, words_out, peak_level on the interface).
// ---------------------------------------------------------------------------
module conv_output_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int AF_MARGIN   = AF_MARGIN_DEF
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    conv_output_buffer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          out_valid_q, out_valid_d;
    out_entry_t    out_q, out_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          push;
    logic          pop;
    out_entry_t    wr_entry;
    out_entry_t    head_entry;

    conv_out_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk        (clk),
        .wr_en_i    (push),
        .wr_addr_i  (wr_ptr_q[AW-1:0]),
        .wr_entry_i (wr_entry),
        .rd_addr_i  (rd_ptr_d[AW-1:0]),
        .rd_entry_o (head_entry)
    );

    // NOTE: every signal driven here gets a value on every path (defaults or
    // full if/else), so no latches are inferred.
    always_comb begin
        wr_entry = '{data: bus.in_data, x: bus.in_x, y: bus.in_y, ch: bus.in_ch};

        // Full: same slot index, opposite wrap bit.
        full = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
        pop  = out_valid_q && bus.out_ready;
        // A pop in the same cycle frees the slot the push needs.
        push = bus.in_valid && (!full || pop);

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = wr_ptr_d - rd_ptr_d;

        // Only entries written at earlier edges may be loaded into the head
        // register, so a word is never presented in the cycle it is written.
        out_valid_d = (wr_ptr_q != rd_ptr_d);
        out_d       = out_valid_d ? head_entry : out_q;

        almost_full_d = (32'(level_d) + 32'(AF_MARGIN)) >= 32'(DEPTH);
        overflow_d    = overflow_q || (bus.in_valid && full && !pop);
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            out_valid_q   <= 1'b0;
            out_q         <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            out_valid_q   <= out_valid_d;
            out_q         <= out_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_q.data;
    assign bus.out_x       = out_q.x;
    assign bus.out_y       = out_q.y;
    assign bus.out_ch      = out_q.ch;
    assign bus.almost_full = almost_full_q;
    assign bus.overflow    = overflow_q;
    assign bus.level       = level_q;

`ifdef CONV_OUTPUT_BUFFER_STATS_EN
    logic [31:0]   stall_cycles_q, stall_cycles_d;
    logic [31:0]   words_out_q, words_out_d;
    logic [PW-1:0] peak_level_q, peak_level_d;

    // Counters saturate rather than wrap so a long run never reads as short.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        words_out_d    = words_out_q;
        peak_level_d   = peak_level_q;
        if (out_valid_q && !bus.out_ready && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (pop && (words_out_q != '1)) begin
            words_out_d = words_out_q + 32'd1;
        end
        if (level_d > peak_level_q) begin
            peak_level_d = level_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            stall_cycles_q <= '0;
            words_out_q    <= '0;
            peak_level_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            words_out_q    <= words_out_d;
            peak_level_q   <= peak_level_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.words_out    = words_out_q;
    assign bus.peak_level   = peak_level_q;
`endif

endmodule

// File: tb/tb_conv_output_buffer.sv
// ---------------------------------------------------------------------------
// tb_conv_output_buffer
// Directed bench for conv_output_buffer (DEPTH=16, AF_MARGIN=6): reset state,
// single word latency, backpressure, overflow, full push+pop, wrap-around
// streaming under almost_full flow control, and reset mid-operation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_output_buffer;
    import conv_pkg::*;

    logic clk;
    logic arst_n_in;
    int   errors = 0;
    int   checks = 0;

    conv_output_buffer_if #(.DATA_WIDTH(32), .COORD_WIDTH(32), .DEPTH(16)) bus ();

    conv_output_buffer #(
        .DATA_WIDTH  (32),
        .COORD_WIDTH (32),
        .DEPTH       (16),
        .AF_MARGIN   (6)
    ) dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_word();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h12;
        bus.in_x      = 32'd3;
        bus.in_y      = 32'd4;
        bus.in_ch     = 32'd5;
        tick();
        bus.in_valid  = 1'b0;
        check("sw_not_same_cycle", 64'(bus.out_valid), 64'(0));
        check("sw_level_1", 64'(bus.level), 64'(1));
        tick();
        check("sw_valid", 64'(bus.out_valid), 64'(1));
        check("sw_data", 64'(bus.out_data), 64'(32'h12));
        check("sw_x", 64'(bus.out_x), 64'(3));
        check("sw_y", 64'(bus.out_y), 64'(4));
        check("sw_ch", 64'(bus.out_ch), 64'(5));
        tick();
        check("sw_valid_drop", 64'(bus.out_valid), 64'(0));
        check("sw_level_0", 64'(bus.level), 64'(0));
        check("sw_data_hold", 64'(bus.out_data), 64'(32'h12));
        bus.out_ready = 1'b0;
    endtask

    // Push 16 words base..base+15 with no consumer; almost_full at level>=10.
    task automatic fill16(input int base);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(base + i);
            bus.in_x     = 32'(i);
            tick();
            check("fill_level", 64'(bus.level), 64'(i + 1));
            check("fill_af", 64'(bus.almost_full), 64'((i + 1) >= 10));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int base, input int n);
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_valid", 64'(bus.out_valid), 64'(1));
            check("drain_data", 64'(bus.out_data), 64'(base + i));
            tick();
        end
    endtask

    initial begin : stim
        int sent;
        int rcvd;
        int cyc;

        arst_n_in     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_ch     = '0;
        bus.out_ready = 1'b0;
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_level", 64'(bus.level), 64'(0));
        check("rst_af", 64'(bus.almost_full), 64'(0));
        check("rst_ovf", 64'(bus.overflow), 64'(0));
        check("rst_data", 64'(bus.out_data), 64'(0));
        check("rst_ch", 64'(bus.out_ch), 64'(0));
        tick();
        arst_n_in = 1'b1;
        tick();

        // Single word round trip.
        single_word();

        // Backpressure: fill, head holds word 0, then drain in order.
        fill16(0);
        tick();
        check("bp_level_16", 64'(bus.level), 64'(16));
        check("bp_head_held", 64'(bus.out_data), 64'(0));
        check("bp_no_ovf", 64'(bus.overflow), 64'(0));
        drain(0, 16);
        check("bp_empty", 64'(bus.out_valid), 64'(0));
        check("bp_level_0", 64'(bus.level), 64'(0));
        check("bp_af_clear", 64'(bus.almost_full), 64'(0));

        // Overflow: extra word dropped, flag sticky.
        fill16(0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD;
        tick();
        bus.in_valid = 1'b0;
        check("ovf_set", 64'(bus.overflow), 64'(1));
        check("ovf_level", 64'(bus.level), 64'(16));
        tick();
        check("ovf_sticky", 64'(bus.overflow), 64'(1));
        drain(0, 16);
        check("ovf_empty", 64'(bus.out_valid), 64'(0));
        check("ovf_still", 64'(bus.overflow), 64'(1));
        bus.out_ready = 1'b0;
        arst_n_in = 1'b0;
        #2;
        check("ovf_cleared_by_rst", 64'(bus.overflow), 64'(0));
        tick();
        arst_n_in = 1'b1;
        tick();

        // Full with simultaneous push and pop.
        fill16(32'h100);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hBEEF;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        check("fpp_level", 64'(bus.level), 64'(16));
        check("fpp_no_ovf", 64'(bus.overflow), 64'(0));
        drain(32'h101, 15);
        check("fpp_last_valid", 64'(bus.out_valid), 64'(1));
        check("fpp_last_data", 64'(bus.out_data), 64'(32'hBEEF));
        tick();
        check("fpp_empty", 64'(bus.out_valid), 64'(0));
        check("fpp_level_0", 64'(bus.level), 64'(0));

        // Wrap-around: 40 words, producer honours almost_full, consumer 1,0,...
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 40 && cyc < 400) begin
            bus.out_ready = ((cyc % 2) == 0);
            bus.in_valid  = (sent < 40) && !bus.almost_full;
            bus.in_data   = 32'(sent);
            bus.in_x      = 32'(sent + 7);
            if (bus.out_valid && bus.out_ready) begin
                check("wrap_data", 64'(bus.out_data), 64'(rcvd));
                check("wrap_x", 64'(bus.out_x), 64'(rcvd + 7));
                rcvd++;
            end
            if (bus.in_valid) sent++;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("wrap_count", 64'(rcvd), 64'(40));
        check("wrap_no_ovf", 64'(bus.overflow), 64'(0));
        check("wrap_level_0", 64'(bus.level), 64'(0));

        // Reset mid-operation at level 7.
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(32'h50 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("mid_level_7", 64'(bus.level), 64'(7));
        check("mid_valid", 64'(bus.out_valid), 64'(1));
        arst_n_in = 1'b0;
        #2;
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_level", 64'(bus.level), 64'(0));
        check("mid_rst_af", 64'(bus.almost_full), 64'(0));
        check("mid_rst_ovf", 64'(bus.overflow), 64'(0));
        check("mid_rst_data", 64'(bus.out_data), 64'(0));
        tick();
        arst_n_in = 1'b1;
        tick();
        single_word();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
